// File: rtl/array_feeder_4.sv
// Input-side sequencer for the 4x4 binary-serial systolic array: weight-tile load, ifm streaming, output drain.
// Define ARRAY_FEEDER_SKEW_EN to add the per-row h-cycle skew delay lines (and the longer flush).
module array_feeder_4 #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int IWIDTH = 8,
  parameter int IDEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  input  logic                      i_w_valid,
  output logic                      o_w_ready,
  input  logic [WIDTH*IWIDTH-1:0]   i_w_data,
  input  logic                      i_s_valid,
  output logic                      o_s_ready,
  input  logic                      i_s_last,
  input  logic [HEIGHT*IWIDTH-1:0]  i_s_ifm,
  output logic [HEIGHT-1:0]         o_en_i,
  output logic [HEIGHT-1:0]         o_clr_i,
  output logic [HEIGHT-1:0]         o_mac_done,
  output logic [HEIGHT*IWIDTH-1:0]  o_ifm,
  output logic [WIDTH-1:0]          o_en_w,
  output logic [WIDTH-1:0]          o_clr_w,
  output logic [WIDTH*IWIDTH-1:0]   o_wght,
  output logic [WIDTH-1:0]          o_en_o,
  output logic [WIDTH-1:0]          o_clr_o
);

  localparam int MAC_CYC = 2 ** IDEPTH;
`ifdef ARRAY_FEEDER_SKEW_EN
  localparam int FLUSH = WIDTH + HEIGHT - 1;
`else
  localparam int FLUSH = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + HEIGHT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_WAIT, S_DRAIN} state_t;

  state_t                    r_state, w_next;
  logic                      r_w_first;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDEPTH-1:0]         r_phase;
  logic                      r_held, r_clr_cur, r_first_pend, r_last_acc;
  logic [HEIGHT*IWIDTH-1:0]  r_vec;
  logic                      r_en_w;
  logic [WIDTH*IWIDTH-1:0]   r_wght;

  logic w_w_ready, w_w_acc, w_ph_end, w_s_ready, w_s_acc, w_en0, w_md0, w_clr0;

  assign w_w_ready = (r_state == S_LOAD_W) && !r_w_first;
  assign w_w_acc   = w_w_ready && i_w_valid;
  assign w_ph_end  = (r_phase == IDEPTH'(MAC_CYC - 1));
  assign w_s_ready = (r_state == S_STREAM) && (!r_held || w_ph_end) && !r_last_acc;
  assign w_s_acc   = w_s_ready && i_s_valid;
  assign w_en0     = (r_state == S_STREAM) && r_held;
  assign w_md0     = w_en0 && w_ph_end;
  assign w_clr0    = w_en0 && r_clr_cur;

  // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output and next-state term gets a default first, so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    o_busy  = (r_state != S_IDLE);
    o_done  = 1'b0;
    o_clr_w = '0;
    o_en_o  = '0;
    o_clr_o = '0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_LOAD_W;
      S_LOAD_W: begin
        o_clr_w = {WIDTH{r_w_first}};
        if (w_w_acc && r_cnt == CNT_W'(HEIGHT - 1)) w_next = S_STREAM;
      end
      S_STREAM: if (w_md0 && r_last_acc) w_next = S_WAIT;
      S_WAIT:   if (r_cnt == CNT_W'(FLUSH - 1)) w_next = S_DRAIN;
      S_DRAIN: begin
        if (r_cnt < CNT_W'(HEIGHT)) begin
          o_en_o = '1;
        end else begin
          o_clr_o = '1;
          o_done  = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w_first    <= 1'b0;
      r_cnt        <= '0;
      r_phase      <= '0;
      r_held       <= 1'b0;
      r_clr_cur    <= 1'b0;
      r_first_pend <= 1'b0;
      r_last_acc   <= 1'b0;
      r_vec        <= '0;
      r_en_w       <= 1'b0;
      r_wght       <= '0;
    end else begin
      r_w_first <= (r_state == S_IDLE) && i_start;
      r_en_w    <= w_w_acc;
      if (w_w_acc) r_wght <= i_w_data;

      // One counter serves weight rows, flush cycles and drain cycles; it restarts on every state change.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_w_acc || r_state == S_WAIT || r_state == S_DRAIN)
        r_cnt <= r_cnt + CNT_W'(1);

      if (r_w_first) begin
        r_first_pend <= 1'b1;
        r_last_acc   <= 1'b0;
        r_held       <= 1'b0;
      end else if (w_s_acc) begin
        r_held       <= 1'b1;
        r_phase      <= '0;
        r_vec        <= i_s_ifm;
        r_clr_cur    <= r_first_pend;
        r_first_pend <= 1'b0;
        r_last_acc   <= i_s_last;
      end else if (w_md0) begin
        r_held <= 1'b0;
      end else if (r_held) begin
        r_phase <= r_phase + IDEPTH'(1);
      end
    end
  end

  assign o_w_ready     = w_w_ready;
  assign o_s_ready     = w_s_ready;
  assign o_en_w        = {WIDTH{r_en_w}};
  assign o_wght        = r_wght;
  assign o_en_i[0]     = w_en0;
  assign o_clr_i[0]    = w_clr0;
  assign o_mac_done[0] = w_md0;
  assign o_ifm[IWIDTH-1:0] = r_vec[IWIDTH-1:0];

`ifdef ARRAY_FEEDER_SKEW_EN
  for (genvar h = 1; h < HEIGHT; h++) begin : g_skew
    logic [IWIDTH+2:0] r_dly [h];

    // NOTE: the delay line is cleared on reset so an aborted tile cannot leak strobes afterwards.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < h; k++) r_dly[k] <= '0;
      end else begin
        r_dly[0] <= {w_en0, w_clr0, w_md0, r_vec[h*IWIDTH +: IWIDTH]};
        for (int k = 1; k < h; k++) r_dly[k] <= r_dly[k-1];
      end
    end

    assign {o_en_i[h], o_clr_i[h], o_mac_done[h], o_ifm[h*IWIDTH +: IWIDTH]} = r_dly[h-1];
  end
`else
  for (genvar h = 1; h < HEIGHT; h++) begin : g_align
    assign o_en_i[h]                  = w_en0;
    assign o_clr_i[h]                 = w_clr0;
    assign o_mac_done[h]              = w_md0;
    assign o_ifm[h*IWIDTH +: IWIDTH]  = r_vec[h*IWIDTH +: IWIDTH];
  end
`endif

endmodule
